// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   mul_state_t : controller states (IDLE, RUN, SIGN, DONE)
//   MUL_WIDTH   : default operand width
//   clog2()     : bit-counter width helper
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int unsigned MUL_WIDTH = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_twos_negate.sv
// Combinational conditional two's-complement negate.
//   x   : W-bit input
//   neg : 1 -> y = -x (mod 2^W), 0 -> y = x
//   y   : W-bit result
module mul_twos_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  always_comb begin
    y = neg ? ('0 - x) : x;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, signed/unsigned at runtime.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   a, b, is_signed      : multiplicand, multiplier, two's-complement mode
//   out_valid/out_ready  : product handshake
//   y                    : 2*WIDTH-bit product register
//   busy                 : high while in RUN or SIGN
// Optional macro SEQ_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (zero |b| goes straight to SIGN).
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    acc_fix;
  logic [PW-1:0]    addend;

  mul_twos_negate #(.W(WIDTH)) u_mag_a (
    .x   (a),
    .neg (is_signed & a[WIDTH-1]),
    .y   (mag_a)
  );

  mul_twos_negate #(.W(WIDTH)) u_mag_b (
    .x   (b),
    .neg (is_signed & b[WIDTH-1]),
    .y   (mag_b)
  );

  mul_twos_negate #(.W(PW)) u_sign_fix (
    .x   (acc_q),
    .neg (neg_q),
    .y   (acc_fix)
  );

  always_comb begin
    addend = PW'(mcand_q) << cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef SEQ_MUL_EARLY_TERM_EN
          if (mag_b == '0) state_d = SIGN;
`endif
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + addend;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = SIGN;
`ifdef SEQ_MUL_EARLY_TERM_EN
        if (mplier_d == '0) state_d = SIGN;
`endif
      end
      SIGN: begin
        y_d         = acc_fix;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status flags are registered from the next state.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == RUN) || (state_d == SIGN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule
